// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator: axis phase encoding,
// default 640x480@60 geometry and the per-axis total derivation.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  localparam int unsigned DEF_CLK_DIV  = 2;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam logic        DEF_SYNC_POL = 1'b0;

  localparam int unsigned POS_H_W = 11;
  localparam int unsigned POS_V_W = 10;

  function automatic int unsigned axis_total(input int unsigned act,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
// Exports the next-state phase so the parent can register its decodes in step with count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter int unsigned WIDTH  = POS_H_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output phase_e           phase_d,
  output logic             wrap
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [WIDTH-1:0] LAST_ACTIVE = WIDTH'(ACTIVE - 1);
  localparam logic [WIDTH-1:0] LAST_FRONT  = WIDTH'(ACTIVE + FP - 1);
  localparam logic [WIDTH-1:0] LAST_SYNC   = WIDTH'(ACTIVE + FP + SYNC - 1);
  localparam logic [WIDTH-1:0] LAST        = WIDTH'(TOTAL - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  phase_e           phase_q;

  assign wrap  = en && (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
      case (phase_q)
        PH_ACTIVE: if (count_q == LAST_ACTIVE) phase_d = PH_FRONT;
        PH_FRONT:  if (count_q == LAST_FRONT)  phase_d = PH_SYNC;
        PH_SYNC:   if (count_q == LAST_SYNC)   phase_d = PH_BACK;
        PH_BACK:   if (count_q == LAST)        phase_d = PH_ACTIVE;
        default:                               phase_d = PH_BACK;
      endcase
    end
  end

  // Reset parks the axis on its last position so the first tick lands on 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= LAST;
      phase_q <= PH_BACK;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, H/V axis counters and
// registered sync, blanking and start-of-line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = DEF_SYNC_POL
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               pix_tick,
  output logic [POS_H_W-1:0] pos_h,
  output logic [POS_V_W-1:0] pos_v,
  output logic               hsync,
  output logic               vsync,
  output logic               disp_en,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned   DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  logic   h_wrap;
  logic   v_wrap;
  phase_e h_phase_d;
  phase_e v_phase_d;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .WIDTH  (POS_H_W)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (tick),
    .count   (pos_h),
    .phase_d (h_phase_d),
    .wrap    (h_wrap)
  );

  // h_wrap already includes tick, so it is exactly the line-wrap advance.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .WIDTH  (POS_V_W)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (h_wrap),
    .count   (pos_v),
    .phase_d (v_phase_d),
    .wrap    (v_wrap)
  );

  logic pix_tick_q,    pix_tick_d;
  logic line_start_q,  line_start_d;
  logic frame_start_q, frame_start_d;
  logic hsync_q,       hsync_d;
  logic vsync_q,       vsync_d;
  logic disp_en_q,     disp_en_d;

  // Decodes use the counters' next phase so they land on the same edge as pos_h/pos_v.
  always_comb begin
    pix_tick_d    = tick;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
    hsync_d       = (h_phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (v_phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    disp_en_d     = (h_phase_d == PH_ACTIVE) && (v_phase_d == PH_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q         <= '0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      disp_en_q     <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      disp_en_q     <= disp_en_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign disp_en     = disp_en_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-reset scoreboard bench for vga_timing_gen: three geometries checked
// every clock against a tick-count arithmetic model of the raster.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pix_tick;
    logic [10:0] pos_h;
    logic [9:0]  pos_v;
    logic        hsync;
    logic        vsync;
    logic        disp_en;
    logic        line_start;
    logic        frame_start;
  } obs_t;

  typedef struct {
    int ha, hfp, hs, hbp;
    int va, vfp, vs, vbp;
    int div;
    bit pol;
  } cfg_t;

  localparam int N_CYCLES   = 20000;
  localparam int QUIET_HEAD = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // A: default geometry and divider; B: tiny raster, divide-by-3;
  // C: tiny raster, divide-by-1, active-high sync.
  logic        a_tick, a_hs, a_vs, a_de, a_ls, a_fs;
  logic [10:0] a_h;
  logic [9:0]  a_v;
  logic        b_tick, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [10:0] b_h;
  logic [9:0]  b_v;
  logic        c_tick, c_hs, c_vs, c_de, c_ls, c_fs;
  logic [10:0] c_h;
  logic [9:0]  c_v;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst_n(rst_n), .pix_tick(a_tick), .pos_h(a_h), .pos_v(a_v),
    .hsync(a_hs), .vsync(a_vs), .disp_en(a_de), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pix_tick(b_tick), .pos_h(b_h), .pos_v(b_v),
    .hsync(b_hs), .vsync(b_vs), .disp_en(b_de), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(2), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b1)
  ) u_dut_c (
    .clk(clk), .rst_n(rst_n), .pix_tick(c_tick), .pos_h(c_h), .pos_v(c_v),
    .hsync(c_hs), .vsync(c_vs), .disp_en(c_de), .line_start(c_ls), .frame_start(c_fs)
  );

  obs_t got_a, got_b, got_c;
  assign got_a = {a_tick, a_h, a_v, a_hs, a_vs, a_de, a_ls, a_fs};
  assign got_b = {b_tick, b_h, b_v, b_hs, b_vs, b_de, b_ls, b_fs};
  assign got_c = {c_tick, c_h, c_v, c_hs, c_vs, c_de, c_ls, c_fs};

  obs_t q_a[$];
  obs_t q_b[$];
  obs_t q_c[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  function automatic cfg_t make_cfg(int ha, int hfp, int hs, int hbp,
                                    int va, int vfp, int vs, int vbp,
                                    int div, bit pol);
    cfg_t g;
    g.ha = ha; g.hfp = hfp; g.hs = hs; g.hbp = hbp;
    g.va = va; g.vfp = vfp; g.vs = vs; g.vbp = vbp;
    g.div = div; g.pol = pol;
    return g;
  endfunction

  // Expected outputs after `edges` clock edges since the last reset edge:
  // tick n happens on edge n*div and shows raster index n-1.
  function automatic obs_t model(cfg_t g, int edges);
    obs_t e;
    int ht, vt, ph, pv, n, lin;
    bit tk;
    ht = g.ha + g.hfp + g.hs + g.hbp;
    vt = g.va + g.vfp + g.vs + g.vbp;
    if (edges < g.div) begin
      ph = ht - 1;
      pv = vt - 1;
      tk = 1'b0;
    end else begin
      n   = edges / g.div;
      lin = (n - 1) % (ht * vt);
      ph  = lin % ht;
      pv  = lin / ht;
      tk  = ((edges % g.div) == 0);
    end
    e.pix_tick    = tk;
    e.pos_h       = 11'(ph);
    e.pos_v       = 10'(pv);
    e.hsync       = (ph >= g.ha + g.hfp && ph < g.ha + g.hfp + g.hs) ? g.pol : ~g.pol;
    e.vsync       = (pv >= g.va + g.vfp && pv < g.va + g.vfp + g.vs) ? g.pol : ~g.pol;
    e.disp_en     = (ph < g.ha) && (pv < g.va);
    e.line_start  = tk && (ph == 0);
    e.frame_start = tk && (ph == 0) && (pv == 0);
    return e;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s cyc=%0d got tick=%0b h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b required tick=%0b h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b",
                 name, cyc,
                 got.pix_tick, got.pos_h, got.pos_v, got.hsync, got.vsync,
                 got.disp_en, got.line_start, got.frame_start,
                 exp.pix_tick, exp.pos_h, exp.pos_v, exp.hsync, exp.vsync,
                 exp.disp_en, exp.line_start, exp.frame_start);
    end
  endtask

  // Monitor: every DUT edge presents a new output word; pop and compare.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) check("dut_a", got_a, q_a.pop_front());
      if (q_b.size() > 0) check("dut_b", got_b, q_b.pop_front());
      if (q_c.size() > 0) check("dut_c", got_c, q_c.pop_front());
    end
  end

  // Driver: chooses rst_n for the next edge and pushes the expected result of that edge.
  initial begin
    cfg_t cfg_a, cfg_b, cfg_c;
    int edges    = 0;
    int rst_left = 0;
    cfg_a = make_cfg(640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0);
    cfg_b = make_cfg(8, 2, 3, 2, 4, 1, 2, 1, 3, 1'b0);
    cfg_c = make_cfg(5, 1, 2, 1, 3, 2, 1, 2, 1, 1'b1);

    for (int i = 0; i < N_CYCLES; i++) begin
      @(negedge clk);
      cyc = i;
      if (i < 3) begin
        rst_n = 1'b0;
      end else if (rst_left > 0) begin
        rst_n = 1'b0;
        rst_left--;
      end else if (i > QUIET_HEAD && $urandom_range(0, 499) == 0) begin
        rst_n    = 1'b0;
        rst_left = int'($urandom_range(0, 2));
        $display("[TB] cycle %0d: reset pulse of %0d clk(s) after %0d edges", i, rst_left + 1, edges);
      end else begin
        rst_n = 1'b1;
      end
      edges = rst_n ? edges + 1 : 0;
      q_a.push_back(model(cfg_a, edges));
      q_b.push_back(model(cfg_b, edges));
      q_c.push_back(model(cfg_c, edges));
    end

    @(posedge clk);
    #2;
    tests++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending entries required 0", q_a.size() + q_b.size() + q_c.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
